// File: rtl/varint_encoder_pkg.sv
// ============================================================================
// Module : varint_encoder_pkg
// Brief  : Shared constants and FSM state encoding for the varint encoder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package varint_encoder_pkg;

  localparam int VARINT_MAX_BYTES = 5;
  localparam int GROUP_W          = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b01,
    ST_EMIT = 2'b10
  } state_t;

endpackage

`default_nettype wire

// File: rtl/varint_encoder.sv
// ============================================================================
// Module : varint_encoder
// Brief  : Streams 32-bit FIFO entries out as protobuf base-128 varint bytes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module varint_encoder
  import varint_encoder_pkg::*;
#(
  parameter int MAX_BYTES = VARINT_MAX_BYTES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        varint_in_fifo_empty,
  input  logic [31:0] varint_in_fifo_data,
  output logic        varint_in_fifo_pop,
  input  logic [9:0]  varint_in_index_data,
  output logic        varint_in_index_pop,
  input  logic        enc_clr,
  output logic        varint_out_valid,
  input  logic        varint_out_ready,
  output logic [7:0]  varint_out_data,
  output logic        varint_out_last,
  output logic [9:0]  varint_out_index,
  output logic [2:0]  varint_out_pos,
  output logic [31:0] varint_count
);

  localparam logic [2:0] LAST_POS = 3'(MAX_BYTES - 1);

  state_t      state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [9:0]  index_q, index_d;
  logic [2:0]  pos_q,   pos_d;
  logic [31:0] count_q, count_d;

  logic emitting;
  logic more;
  logic last_byte;
  logic accept;
  logic pop;

  always_comb begin
    emitting  = (state_q == ST_EMIT);
    // The final position always terminates the varint, whatever is left.
    more      = (shift_q[31:GROUP_W] != '0) && (pos_q != LAST_POS);
    last_byte = !more;
    accept    = emitting && varint_out_ready;
    pop       = !varint_in_fifo_empty && !enc_clr && !reset &&
                (!emitting || (accept && last_byte));

    state_d = state_q;
    shift_d = shift_q;
    index_d = index_q;
    pos_d   = pos_q;
    count_d = count_q;

    if (enc_clr) begin
      state_d = ST_IDLE;
    end else if (pop) begin
      state_d = ST_EMIT;
      shift_d = varint_in_fifo_data;
      index_d = varint_in_index_data;
      pos_d   = 3'd0;
    end else if (accept) begin
      if (last_byte) begin
        state_d = ST_IDLE;
      end else begin
        shift_d = shift_q >> GROUP_W;
        pos_d   = pos_q + 3'd1;
      end
    end

    if (!enc_clr && accept && last_byte) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      index_q <= '0;
      pos_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      index_q <= index_d;
      pos_q   <= pos_d;
      count_q <= count_d;
    end
  end

  // Byte fields are masked outside EMIT so a flushed varint leaves no residue.
  always_comb begin
    varint_in_fifo_pop  = pop;
    varint_in_index_pop = pop;
    varint_out_valid    = emitting;
    varint_out_data     = emitting ? {more, shift_q[GROUP_W-1:0]} : 8'h00;
    varint_out_last     = emitting && last_byte;
    varint_out_pos      = emitting ? pos_q : 3'd0;
    varint_out_index    = emitting ? index_q : 10'd0;
    varint_count        = count_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_varint_encoder.sv
// ============================================================================
// Module : tb_varint_encoder
// Brief  : Self-checking bench for varint_encoder with a show-ahead FIFO model.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_varint_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        varint_in_fifo_empty;
  logic [31:0] varint_in_fifo_data;
  logic        varint_in_fifo_pop;
  logic [9:0]  varint_in_index_data;
  logic        varint_in_index_pop;
  logic        enc_clr;
  logic        varint_out_valid;
  logic        varint_out_ready;
  logic [7:0]  varint_out_data;
  logic        varint_out_last;
  logic [9:0]  varint_out_index;
  logic [2:0]  varint_out_pos;
  logic [31:0] varint_count;

  varint_encoder #(.MAX_BYTES(5)) dut (
    .clk                  (clk),
    .reset                (reset),
    .varint_in_fifo_empty (varint_in_fifo_empty),
    .varint_in_fifo_data  (varint_in_fifo_data),
    .varint_in_fifo_pop   (varint_in_fifo_pop),
    .varint_in_index_data (varint_in_index_data),
    .varint_in_index_pop  (varint_in_index_pop),
    .enc_clr              (enc_clr),
    .varint_out_valid     (varint_out_valid),
    .varint_out_ready     (varint_out_ready),
    .varint_out_data      (varint_out_data),
    .varint_out_last      (varint_out_last),
    .varint_out_index     (varint_out_index),
    .varint_out_pos       (varint_out_pos),
    .varint_count         (varint_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [2:0] pos;
    logic [9:0] index;
  } beat_t;

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          pop_while_empty = 0;
  int          pop_mismatch    = 0;
  int          pop_in_reset    = 0;
  logic [31:0] exp_count   = '0;

  logic [31:0] q_data[$];
  logic [9:0]  q_idx[$];
  beat_t       log_q[$];
  int          log_cyc[$];
  beat_t       exp_q[$];

  function automatic void refresh();
    varint_in_fifo_empty = (q_data.size() == 0);
    varint_in_fifo_data  = varint_in_fifo_empty ? 32'h0 : q_data[0];
    varint_in_index_data = varint_in_fifo_empty ? 10'h0 : q_idx[0];
  endfunction

  // Reference: repeated division by 128, continuation bit while a remainder is left.
  function automatic void model_push(input logic [31:0] v, input logic [9:0] idx);
    longint unsigned rem;
    int              p;
    beat_t           b;
    rem = longint'(v);
    p   = 0;
    do begin
      b.data  = 8'(rem % 128);
      rem     = rem / 128;
      if (rem != 0) b.data[7] = 1'b1;
      b.last  = (rem == 0);
      b.pos   = 3'(p);
      b.index = idx;
      exp_q.push_back(b);
      p++;
    end while (rem != 0);
  endfunction

  task automatic push_entry(input logic [31:0] v, input logic [9:0] idx);
    q_data.push_back(v);
    q_idx.push_back(idx);
    refresh();
  endtask

  task automatic wait_drain(input int mode, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (q_data.size() == 0 && !varint_out_valid) begin
        ok = 1'b1;
        break;
      end
      case (mode)
        0:       varint_out_ready = 1'b1;
        1:       varint_out_ready = !varint_out_ready;
        default: varint_out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  endtask

  // FIFO pop bookkeeping and accepted-byte log.
  always @(posedge clk) begin
    logic popped;
    cyc++;
    popped = varint_in_fifo_pop;
    if (varint_in_fifo_pop !== varint_in_index_pop) pop_mismatch++;
    if (varint_in_fifo_pop && varint_in_fifo_empty) pop_while_empty++;
    if (varint_in_fifo_pop && reset) pop_in_reset++;
    if (varint_out_valid && varint_out_ready && !reset && !enc_clr) begin
      log_q.push_back({varint_out_data, varint_out_last, varint_out_pos, varint_out_index});
      log_cyc.push_back(cyc);
    end
    if (popped) begin
      #1;
      void'(q_data.pop_front());
      void'(q_idx.pop_front());
      refresh();
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    enc_clr = 1'b1;
    varint_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (varint_out_valid !== 1'b0) begin $display("FAIL reset_valid: got %b want 0", varint_out_valid); miscompares++; end
    vectors++; if (varint_in_fifo_pop !== 1'b0) begin $display("FAIL reset_pop: got %b want 0", varint_in_fifo_pop); miscompares++; end
    vectors++; if (varint_out_data !== 8'h00) begin $display("FAIL reset_data: got %h want 00", varint_out_data); miscompares++; end
    vectors++; if (varint_out_last !== 1'b0) begin $display("FAIL reset_last: got %b want 0", varint_out_last); miscompares++; end
    vectors++; if (varint_out_pos !== 3'd0) begin $display("FAIL reset_pos: got %0d want 0", varint_out_pos); miscompares++; end
    vectors++; if (varint_out_index !== 10'd0) begin $display("FAIL reset_index: got %0d want 0", varint_out_index); miscompares++; end
    vectors++; if (varint_count !== 32'd0) begin $display("FAIL reset_count: got %0d want 0", varint_count); miscompares++; end
    reset = 1'b0;
    enc_clr = 1'b0;
    exp_count = '0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    log_q.delete(); log_cyc.delete(); exp_q.delete();
    varint_out_ready = 1'b1;
    push_entry(32'd150, 10'd1);
    model_push(32'd150, 10'd1);
    exp_count++;
    wait_drain(0, ok);
    vectors++; if (!ok) begin $display("FAIL single_timeout: drain not reached"); miscompares++; end
    vectors++; if (log_q.size() != exp_q.size()) begin $display("FAIL single_len: got %0d bytes want %0d", log_q.size(), exp_q.size()); miscompares++; end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      vectors++;
      if (log_q[i] !== exp_q[i]) begin $display("FAIL single_byte[%0d]: got %h want %h (data,last,pos,index)", i, log_q[i], exp_q[i]); miscompares++; end
    end
    vectors++; if (varint_count !== exp_count) begin $display("FAIL single_count: got %0d want %0d", varint_count, exp_count); miscompares++; end
  endtask

  task automatic test_back_to_back();
    bit ok;
    log_q.delete(); log_cyc.delete(); exp_q.delete();
    varint_out_ready = 1'b1;
    push_entry(32'h0,  10'd10); model_push(32'h0,  10'd10);
    push_entry(32'h7F, 10'd11); model_push(32'h7F, 10'd11);
    push_entry(32'h80, 10'd12); model_push(32'h80, 10'd12);
    exp_count += 3;
    wait_drain(0, ok);
    vectors++; if (!ok) begin $display("FAIL b2b_timeout: drain not reached"); miscompares++; end
    vectors++; if (log_q.size() != exp_q.size()) begin $display("FAIL b2b_len: got %0d bytes want %0d", log_q.size(), exp_q.size()); miscompares++; end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      vectors++;
      if (log_q[i] !== exp_q[i]) begin $display("FAIL b2b_byte[%0d]: got %h want %h (data,last,pos,index)", i, log_q[i], exp_q[i]); miscompares++; end
      vectors++;
      if (log_cyc[i] != log_cyc[0] + i) begin $display("FAIL b2b_bubble[%0d]: got cycle %0d want %0d", i, log_cyc[i], log_cyc[0] + i); miscompares++; end
    end
    vectors++; if (varint_count !== exp_count) begin $display("FAIL b2b_count: got %0d want %0d", varint_count, exp_count); miscompares++; end
  endtask

  task automatic test_stall();
    bit    done;
    bit    pend;
    beat_t saved;
    beat_t cur;
    log_q.delete(); log_cyc.delete(); exp_q.delete();
    varint_out_ready = 1'b0;
    pend = 1'b0;
    done = 1'b0;
    push_entry(32'hFFFF_FFFF, 10'd2);
    model_push(32'hFFFF_FFFF, 10'd2);
    exp_count++;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      cur = {varint_out_data, varint_out_last, varint_out_pos, varint_out_index};
      if (pend) begin
        vectors++;
        if (!varint_out_valid || cur !== saved) begin $display("FAIL stall_hold: got valid=%b %h want valid=1 %h", varint_out_valid, cur, saved); miscompares++; end
      end
      if (q_data.size() == 0 && !varint_out_valid) done = 1'b1;
      varint_out_ready = !varint_out_ready;
      pend  = varint_out_valid && !varint_out_ready;
      saved = cur;
    end
    vectors++; if (!done) begin $display("FAIL stall_timeout: drain not reached"); miscompares++; end
    vectors++; if (log_q.size() != exp_q.size()) begin $display("FAIL stall_len: got %0d bytes want %0d", log_q.size(), exp_q.size()); miscompares++; end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      vectors++;
      if (log_q[i] !== exp_q[i]) begin $display("FAIL stall_byte[%0d]: got %h want %h (data,last,pos,index)", i, log_q[i], exp_q[i]); miscompares++; end
    end
    vectors++; if (varint_count !== exp_count) begin $display("FAIL stall_count: got %0d want %0d", varint_count, exp_count); miscompares++; end
  endtask

  task automatic test_clr();
    bit ok;
    bit seen;
    log_q.delete(); log_cyc.delete(); exp_q.delete();
    varint_out_ready = 1'b1;
    seen = 1'b0;
    push_entry(32'hFFFF_FFFF, 10'd2);
    push_entry(32'd1, 10'd3);
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (log_q.size() >= 2) seen = 1'b1;
    end
    vectors++; if (!seen) begin $display("FAIL clr_timeout: two bytes not seen"); miscompares++; end
    vectors++; if (log_q.size() < 2 || log_q[0].data !== 8'hFF || log_q[1].data !== 8'hFF) begin $display("FAIL clr_prefix: got %0d bytes want FF FF", log_q.size()); miscompares++; end
    enc_clr = 1'b1;
    @(negedge clk);
    vectors++; if (varint_out_valid !== 1'b0) begin $display("FAIL clr_valid: got %b want 0", varint_out_valid); miscompares++; end
    vectors++; if (varint_count !== exp_count) begin $display("FAIL clr_count: got %0d want %0d", varint_count, exp_count); miscompares++; end
    vectors++; if (q_data.size() != 1) begin $display("FAIL clr_nopop: got %0d entries left want 1", q_data.size()); miscompares++; end
    enc_clr = 1'b0;
    log_q.delete(); log_cyc.delete();
    model_push(32'd1, 10'd3);
    exp_count++;
    wait_drain(0, ok);
    vectors++; if (!ok) begin $display("FAIL clr_drain_timeout: drain not reached"); miscompares++; end
    vectors++; if (log_q.size() != exp_q.size()) begin $display("FAIL clr_len: got %0d bytes want %0d", log_q.size(), exp_q.size()); miscompares++; end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      vectors++;
      if (log_q[i] !== exp_q[i]) begin $display("FAIL clr_byte[%0d]: got %h want %h (data,last,pos,index)", i, log_q[i], exp_q[i]); miscompares++; end
    end
    vectors++; if (varint_count !== exp_count) begin $display("FAIL clr_after_count: got %0d want %0d", varint_count, exp_count); miscompares++; end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    log_q.delete(); log_cyc.delete(); exp_q.delete();
    varint_out_ready = 1'b1;
    seen = 1'b0;
    push_entry(32'h1234_5678, 10'd4);
    push_entry(32'h0000_3FFF, 10'd5);
    push_entry(32'h0000_0055, 10'd6);
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (log_q.size() >= 1) seen = 1'b1;
    end
    vectors++; if (!seen) begin $display("FAIL rstmid_timeout: first byte not seen"); miscompares++; end
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (varint_out_valid !== 1'b0 || varint_out_data !== 8'h00 || varint_out_last !== 1'b0 ||
                   varint_out_pos !== 3'd0 || varint_out_index !== 10'd0) begin
      $display("FAIL rstmid_outputs: got valid=%b data=%h last=%b pos=%0d idx=%0d want all 0",
               varint_out_valid, varint_out_data, varint_out_last, varint_out_pos, varint_out_index);
      miscompares++;
    end
    vectors++; if (varint_count !== 32'd0) begin $display("FAIL rstmid_count: got %0d want 0", varint_count); miscompares++; end
    vectors++; if (varint_in_fifo_pop !== 1'b0) begin $display("FAIL rstmid_pop: got %b want 0", varint_in_fifo_pop); miscompares++; end
    vectors++; if (q_data.size() != 2) begin $display("FAIL rstmid_fifo: got %0d entries want 2", q_data.size()); miscompares++; end
    reset = 1'b0;
    exp_count = 32'd2;
    log_q.delete(); log_cyc.delete();
    model_push(32'h0000_3FFF, 10'd5);
    model_push(32'h0000_0055, 10'd6);
    wait_drain(0, ok);
    vectors++; if (!ok) begin $display("FAIL rstmid_drain_timeout: drain not reached"); miscompares++; end
    vectors++; if (log_q.size() != exp_q.size()) begin $display("FAIL rstmid_len: got %0d bytes want %0d", log_q.size(), exp_q.size()); miscompares++; end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      vectors++;
      if (log_q[i] !== exp_q[i]) begin $display("FAIL rstmid_byte[%0d]: got %h want %h (data,last,pos,index)", i, log_q[i], exp_q[i]); miscompares++; end
    end
    vectors++; if (varint_count !== exp_count) begin $display("FAIL rstmid_after_count: got %0d want %0d", varint_count, exp_count); miscompares++; end
  endtask

  task automatic test_random();
    bit          ok;
    logic [31:0] v;
    logic [9:0]  idx;
    logic [31:0] edges[6];
    edges = '{32'h7F, 32'h80, 32'h3FFF, 32'h4000, 32'h0FFF_FFFF, 32'h1000_0000};
    log_q.delete(); log_cyc.delete(); exp_q.delete();
    foreach (edges[k]) begin
      idx = 10'($urandom);
      push_entry(edges[k], idx);
      model_push(edges[k], idx);
      exp_count++;
    end
    for (int b = 0; b < 8; b++) begin
      for (int n = 0; n < int'($urandom_range(1, 8)); n++) begin
        v   = $urandom >> $urandom_range(0, 31);
        idx = 10'($urandom);
        push_entry(v, idx);
        model_push(v, idx);
        exp_count++;
      end
      wait_drain(2, ok);
      vectors++; if (!ok) begin $display("FAIL rand_timeout: batch %0d not drained", b); miscompares++; end
    end
    vectors++; if (log_q.size() != exp_q.size()) begin $display("FAIL rand_len: got %0d bytes want %0d", log_q.size(), exp_q.size()); miscompares++; end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      vectors++;
      if (log_q[i] !== exp_q[i]) begin $display("FAIL rand_byte[%0d]: got %h want %h (data,last,pos,index)", i, log_q[i], exp_q[i]); miscompares++; end
    end
    vectors++; if (varint_count !== exp_count) begin $display("FAIL rand_count: got %0d want %0d", varint_count, exp_count); miscompares++; end
    vectors++; if (pop_while_empty != 0) begin $display("FAIL pop_empty: got %0d pops on empty want 0", pop_while_empty); miscompares++; end
    vectors++; if (pop_mismatch != 0) begin $display("FAIL pop_pair: got %0d index/data pop mismatches want 0", pop_mismatch); miscompares++; end
    vectors++; if (pop_in_reset != 0) begin $display("FAIL pop_reset: got %0d pops during reset want 0", pop_in_reset); miscompares++; end
  endtask

  initial begin
    reset            = 1'b1;
    enc_clr          = 1'b0;
    varint_out_ready = 1'b0;
    refresh();
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_clr();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/varint_encoder.md
VARINT_ENCODER -- requirements
Module: varint_encoder

Interface
REQ-001 Parameter: MAX_BYTES, default 5; maximum varint length in bytes for a 32-bit value.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk  in  1  system clock; one clock, all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- varint_in_fifo_empty  in  1  varint input FIFO has no entry.
- varint_in_fifo_data  in  32  head value; show-ahead, valid while empty=0.
- varint_in_fifo_pop  out  1  consume head of varint data FIFO.
- varint_in_index_data  in  10  head message index; paired 1:1 with the data FIFO.
- varint_in_index_pop  out  1  consume head of index FIFO; always equal to varint_in_fifo_pop.
- enc_clr  in  1  synchronous flush of the in-flight varint.
- varint_out_valid  out  1  output byte valid.
- varint_out_ready  in  1  downstream accepts byte.
- varint_out_data  out  8  encoded byte.
- varint_out_last  out  1  final byte of the current varint.
- varint_out_index  out  10  message index of the current varint.
- varint_out_pos  out  3  byte position within the varint, 0..4.
- varint_count  out  32  total varints fully emitted.

Function
REQ-003 The encoder SHALL convert each 32-bit unsigned FIFO entry into protobuf base-128 varint bytes, least-significant 7-bit group first.
REQ-004 Each byte SHALL be {more, group[6:0]}, where more=1 iff the remaining value shifted right by 7 is nonzero.
REQ-005 A value of 0 SHALL emit exactly one byte, 0x00, with last=1.
REQ-006 The byte count SHALL be 1..5; value 0xFFFFFFFF SHALL emit FF FF FF FF 0F.
REQ-007 FSM states SHALL be IDLE and EMIT.
REQ-008 IDLE, empty=1: stay in IDLE; pop=0, valid=0.
REQ-009 IDLE, empty=0: assert pop for one cycle; capture data into the shift register and index into the index register; pos<=0; go to EMIT.
REQ-010 EMIT SHALL drive valid=1; data, last, pos and index SHALL be derived from registers only.
REQ-011 EMIT, ready=0: all outputs SHALL hold stable.
REQ-012 EMIT, ready=1, last=0: shift register >>= 7; pos += 1; stay in EMIT.
REQ-013 EMIT, ready=1, last=1, empty=0: pop and load the next entry in the same cycle, stay in EMIT (no bubble), and increment varint_count.
REQ-014 EMIT, ready=1, last=1, empty=1: go to IDLE and increment varint_count.
REQ-015 Pop SHALL never be asserted while empty=1, and never more than once per varint.
REQ-016 varint_count SHALL wrap from 0xFFFFFFFF to 0.
REQ-017 pos SHALL never exceed MAX_BYTES-1; pos reaching 4 SHALL force last=1.
REQ-018 enc_clr=1 SHALL return the FSM to IDLE, drop the in-flight varint, and leave varint_count unchanged.
- Its pop is suppressed that cycle.
- enc_clr has priority over every other transition, including a handshake in the same cycle.
REQ-019 Steady-state throughput SHALL be one byte per clock while ready=1 and the FIFO is non-empty.
REQ-020 Latency from FIFO non-empty in IDLE to the first valid byte SHALL be 1 clock.

Reset
REQ-021 reset=1 at a clock edge SHALL force the following, with reset taking priority over enc_clr:
- state=IDLE
- valid=0, pop=0
- data=0x00, last=0, pos=0, index=0
- varint_count=0
REQ-022 Reset mid-varint SHALL discard remaining bytes; no entry SHALL be popped during reset.

Structure
REQ-023 A shared package SHALL hold the following; the datapath FSM module SHALL import it:
- VARINT_MAX_BYTES=5
- the group width 7
- the state encoding (one-hot, 2 bits)
REQ-024 The design SHALL be a single module with no sub-module; the FSM, shift register and counter SHALL be inline.

Verification
REQ-025 Single entry 0x00000096 (150), ready=1 -> bytes 0x96, 0x01; last on the second byte; pos 0,1; count=1.
REQ-026 Entries 0, 0x7F, 0x80 back-to-back, ready=1 -> 00, 7F, 80, 01 on consecutive cycles with no bubble; count=3.
REQ-027 Entry 0xFFFFFFFF, ready toggling 1/0 each cycle -> FF FF FF FF 0F held stable while stalled; pos 0..4; last only on 0x0F.
REQ-028 enc_clr asserted after the second byte of 0xFFFFFFFF -> valid drops next cycle; count unchanged; the next entry (index 3, value 1) emits 0x01 with index 3.
REQ-029 reset asserted mid-varint with the FIFO non-empty -> all outputs at reset values next cycle; no pop during reset; encoding restarts from the FIFO head after release.
